// File: rtl/pipe_io_bank.sv
// rtl/pipe_io_bank.sv - MEM-stage I/O bank: output regs, synced inputs, sticky change flags, irq
module pipe_io_bank #(
  parameter int DATA_W  = 32,
  parameter int NUM_OUT = 3,
  parameter int NUM_IN  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_we,
  input  logic                      io_re,
  input  logic [5:0]                io_addr,
  input  logic [DATA_W-1:0]         io_wdata,
  input  logic [NUM_IN*DATA_W-1:0]  in_port,
  output logic [NUM_OUT*DATA_W-1:0] out_port,
  output logic [DATA_W-1:0]         io_rdata,
  output logic                      io_rvalid,
  output logic                      irq
);

  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $error("pipe_io_bank: NUM_OUT must be 1..8");
  end
  if (NUM_IN < 1 || NUM_IN > 8) begin : g_bad_num_in
    $error("pipe_io_bank: NUM_IN must be 1..8");
  end

  localparam logic [3:0] IDX_MASK   = 4'd13;
  localparam logic [3:0] IDX_STATUS = 4'd14;

  logic [3:0]        idx;
  logic              unused_addr_lsb;
  logic [DATA_W-1:0] out_reg [NUM_OUT];
  logic [DATA_W-1:0] s1      [NUM_IN];
  logic [DATA_W-1:0] in_sync [NUM_IN];
  logic [DATA_W-1:0] prev    [NUM_IN];
  logic [NUM_IN-1:0] mask;
  logic [NUM_IN-1:0] status;
  logic [1:0]        wup;
  logic              armed;

  logic [NUM_IN-1:0] chg;
  logic [NUM_IN-1:0] clr;
  logic [NUM_IN-1:0] status_next;
  logic [NUM_IN-1:0] mask_next;
  logic [DATA_W-1:0] rd_data;

  assign idx             = io_addr[5:2];
  assign unused_addr_lsb = ^io_addr[1:0];
  assign armed           = (wup == 2'd3);

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = out_reg[g];
  end

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      chg[i] = (in_sync[i] != prev[i]) && armed;
    end
    clr         = (io_we && idx == IDX_STATUS) ? io_wdata[NUM_IN-1:0] : '0;
    status_next = (status & ~clr) | chg;
    mask_next   = (io_we && idx == IDX_MASK) ? io_wdata[NUM_IN-1:0] : mask;
  end

  // Read mux sees pre-write state, giving read-before-write on same-cycle access
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == 4'(i)) rd_data = out_reg[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx == 4'(8 + i)) rd_data = in_sync[i];
    end
    if (idx == IDX_MASK)   rd_data[NUM_IN-1:0] = mask;
    if (idx == IDX_STATUS) rd_data[NUM_IN-1:0] = status;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        s1[i]      <= '0;
        in_sync[i] <= '0;
        prev[i]    <= '0;
      end
      mask      <= '0;
      status    <= '0;
      wup       <= '0;
      io_rdata  <= '0;
      io_rvalid <= 1'b0;
      irq       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (io_we && idx == 4'(i)) out_reg[i] <= io_wdata;
      end
      for (int i = 0; i < NUM_IN; i++) begin
        s1[i]      <= in_port[i*DATA_W +: DATA_W];
        in_sync[i] <= s1[i];
        prev[i]    <= in_sync[i];
      end
      if (!armed) wup <= wup + 2'd1;
      mask   <= mask_next;
      status <= status_next;
      // Newly set bits reach irq one edge after status; clears and mask writes act at once
      irq    <= |(status & status_next & mask_next);
      io_rvalid <= io_re;
      if (io_re) io_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_pipe_io_bank.sv
// tb/tb_pipe_io_bank.sv - directed self-checking bench for pipe_io_bank
module tb_pipe_io_bank;

  logic        clock;
  logic        reset;
  logic        io_we;
  logic        io_re;
  logic [5:0]  io_addr;
  logic [31:0] io_wdata;
  logic [63:0] in_port;
  logic [95:0] out_port;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_io_bank #(.DATA_W(32), .NUM_OUT(3), .NUM_IN(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .io_rdata  (io_rdata),
    .io_rvalid (io_rvalid),
    .irq       (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
    io_we    = 1'b1;
    io_addr  = {idx, 2'b00};
    io_wdata = data;
    tick();
    io_we    = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    io_re   = 1'b1;
    io_addr = {idx, 2'b00};
    tick();
    io_re   = 1'b0;
    check({tag, "_data"}, io_rdata, exp);
    check({tag, "_rvalid"}, io_rvalid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    io_we    = 1'b0;
    io_re    = 1'b0;
    io_addr  = '0;
    io_wdata = '0;
    in_port  = {32'hA5A5A5A5, 32'hA5A5A5A5};
    repeat (3) tick();
    reset = 1'b0;
    check("rst_out_port", out_port, 96'h0);
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_rvalid", io_rvalid, 1'b0);
    check("rst_irq", irq, 1'b0);

    // Warm-up must swallow the 0 -> A5A5A5A5 edge in the sync chain
    repeat (4) tick();
    do_read("wup_status", 4'd14, 32'h0);
    check("wup_irq", irq, 1'b0);

    // Real change with mask=0: status sets, irq stays low; then clear it
    in_port = 64'h0;
    repeat (4) tick();
    check("masked_irq", irq, 1'b0);
    do_read("masked_status", 4'd14, 32'h3);
    do_write(4'd14, 32'h3);
    do_read("cleared_status", 4'd14, 32'h0);

    do_write(4'd1, 32'h12345678);
    check("out1", out_port[63:32], 32'h12345678);
    do_write(4'd0, 32'hFFFFFFFF);
    check("out0", out_port[31:0], 32'hFFFFFFFF);
    do_read("rd_idx1", 4'd1, 32'h12345678);
    tick();
    check("idle_rvalid", io_rvalid, 1'b0);
    check("idle_rdata_hold", io_rdata, 32'h12345678);

    // Same-cycle read+write returns old value, then back-to-back read
    do_write(4'd2, 32'h1);
    io_we    = 1'b1;
    io_re    = 1'b1;
    io_addr  = {4'd2, 2'b00};
    io_wdata = 32'h2;
    tick();
    io_we = 1'b0;
    check("rw_old", io_rdata, 32'h1);
    check("rw_out2", out_port[95:64], 32'h2);
    tick();
    io_re = 1'b0;
    check("b2b_data", io_rdata, 32'h2);
    check("b2b_rvalid", io_rvalid, 1'b1);

    // Input change: status at E2, irq at E3
    do_write(4'd13, 32'h3);
    check("mask_irq", irq, 1'b0);
    in_port[63:32] = 32'h5;
    tick();
    check("chg_e0_irq", irq, 1'b0);
    tick();
    check("chg_e1_irq", irq, 1'b0);
    io_re   = 1'b1;
    io_addr = {4'd14, 2'b00};
    tick();
    check("chg_e2_status_old", io_rdata, 32'h0);
    check("chg_e2_irq", irq, 1'b0);
    tick();
    io_re = 1'b0;
    check("chg_e3_status", io_rdata, 32'h2);
    check("chg_e3_irq", irq, 1'b1);
    do_read("rd_in1", 4'd9, 32'h5);
    do_read("rd_mask", 4'd13, 32'h3);

    // W1C colliding with a new change: set wins
    in_port[63:32] = 32'h7;
    tick();
    tick();
    do_write(4'd14, 32'h2);
    check("setwin_irq", irq, 1'b1);
    do_read("setwin_status", 4'd14, 32'h2);
    check("setwin_irq_hold", irq, 1'b1);
    do_write(4'd14, 32'h2);
    check("clr_irq", irq, 1'b0);
    do_read("clr_status", 4'd14, 32'h0);

    // Unmapped indices
    do_write(4'd5, 32'hDEADBEEF);
    do_write(4'd12, 32'hFFFFFFFF);
    check("unmap_out", out_port, {32'h2, 32'h12345678, 32'hFFFFFFFF});
    do_read("rd_idx5", 4'd5, 32'h0);
    do_read("rd_idx12", 4'd12, 32'h0);
    do_read("unmap_mask", 4'd13, 32'h3);
    do_read("unmap_status", 4'd14, 32'h0);
    check("unmap_irq", irq, 1'b0);

    // Mask write drops irq at the same edge
    in_port[63:32] = 32'h0;
    repeat (4) tick();
    check("pre_mask_irq", irq, 1'b1);
    do_write(4'd13, 32'h0);
    check("mask_clr_irq", irq, 1'b0);

    // Mid-operation reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_out", out_port, 96'h0);
    check("mid_rst_rvalid", io_rvalid, 1'b0);
    check("mid_rst_rdata", io_rdata, 32'h0);
    do_read("mid_rst_mask", 4'd13, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
